seg7_scan_reader: RTL

Receive-side counterpart of the team's seven-segment decoder and display driver. It samples a multiplexed seven-segment bus (segments a..g plus one-hot digit selects), qualifies each digit by stability, and maps the segment pattern back to a hex nibble. It assembles a complete multi-digit frame and hands it off over a valid/ready interface. It sits between the display pins (or the driver's outputs in loopback) and the self-check or readback logic.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_glyph_decode.sv | 25 ++
 rtl/seg7_scan_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan reader.
//   SEG_W        : number of segment lines (a..g)
//   GLYPH        : segment pattern (gfedcba, 1=lit) for each hex nibble 0..F
//   samp_state_t : sampler FSM states
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_HOLD
  } samp_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex glyph table.
//   pattern : segment pattern, bit0=a .. bit6=g, 1=lit
//   nibble  : matching hex value, 0 when the pattern is not a glyph
//   err     : 1 when the pattern matches no glyph
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             err
);

  // Glyphs are unique, so at most one entry can match.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed seven-segment bus, qualifies each digit by stability,
// decodes it back to a nibble and hands complete frames off over valid/ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   seg, an      : segment lines and one-hot digit selects (async to clk)
//   frame_data   : recovered value, digit k in bits [4k+3:4k]
//   frame_err    : per-digit illegal-glyph flags
//   frame_valid  : frame pending, held until frame_ready
//   frame_ready  : consumer accept
//   overrun      : sticky, a completed frame was dropped while one was pending
// Build option: define SEG7_ACTIVE_LOW_EN for a common-anode bus (0=lit/selected).
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int BUS_W = SEG_W + NUM_DIGITS;
  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  // ---- synchronizer: {an, seg} as one bus ----
  logic [BUS_W-1:0] sync1, sync2, bus;

`ifdef SEG7_ACTIVE_LOW_EN
  // Reset to all ones so the inverted bus looks blank.
  localparam logic [BUS_W-1:0] SYNC_RST = '1;
  assign bus = ~sync2;
`else
  localparam logic [BUS_W-1:0] SYNC_RST = '0;
  assign bus = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
    end
  end

  logic [NUM_DIGITS-1:0] bus_an;
  logic                  bus_onehot;
  assign bus_an     = bus[BUS_W-1:SEG_W];
  assign bus_onehot = (bus_an != '0) && ((bus_an & (bus_an - NUM_DIGITS'(1))) == '0);

  // ---- sampler ----
  samp_state_t             state;
  logic [BUS_W-1:0]        lat;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] work_data;
  logic [NUM_DIGITS-1:0]   work_err;
  logic                    done;

  logic [NUM_DIGITS-1:0] lat_an;
  logic [3:0]            dec_nib;
  logic                  dec_err;
  assign lat_an = lat[BUS_W-1:SEG_W];

  seg7_glyph_decode u_dec (
    .pattern (lat[SEG_W-1:0]),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat       <= '0;
      cnt       <= '0;
      mask      <= '0;
      work_data <= '0;
      work_err  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus_onehot) begin
            lat   <= bus;
            cnt   <= 8'd1;
            state <= S_TRACK;
          end
        end
        S_TRACK, S_HOLD: begin
          if (bus == lat) begin
            if (state == S_TRACK) begin
              cnt <= cnt + 8'd1;
              if (cnt == LAST_CNT) begin
                state <= S_HOLD;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                  if (lat_an[k]) begin
                    work_data[4*k +: 4] <= dec_nib;
                    work_err[k]         <= dec_err;
                  end
                end
                // Snapshot of work_* happens next cycle; no capture can
                // land there because the sampler sits in HOLD.
                if (&(mask | lat_an)) begin
                  mask <= '0;
                  done <= 1'b1;
                end else begin
                  mask <= mask | lat_an;
                end
              end
            end
          end else if (bus_onehot) begin
            lat   <= bus;
            cnt   <= 8'd1;
            state <= S_TRACK;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- frame handoff ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done) begin
        // A frame completing in the same cycle as a transfer takes the slot.
        if (!frame_valid || frame_ready) begin
          frame_data  <= work_data;
          frame_err   <= work_err;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
